// File: rtl/ibex_pkg.sv
// Shared types for the register-file write-port arbiter and its park FIFO.
package ibex_pkg;

   // Widest RF address the shared request type can carry (up to 256 physical registers).
   localparam int unsigned RfAddrMaxW = 8;

   typedef struct packed {
      logic [RfAddrMaxW-1:0] waddr;
      logic [31:0]           wdata;
   } rf_wr_req_t;

   typedef enum logic [1:0] {
      RF_WR_SRC_NONE,
      RF_WR_SRC_WB,
      RF_WR_SRC_LSU_FIFO,
      RF_WR_SRC_LSU_BYP
   } rf_wr_src_e;

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// Circular FIFO of parked RF write requests; exposes per-entry valid and address
// so the arbiter can build the pending-write mask.
module ibex_rf_wr_fifo
   import ibex_pkg::*;
#(
   parameter int unsigned Depth    = 2,
   parameter bit          ResetAll = 1'b0,
   localparam int unsigned LvlW    = $clog2(Depth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  push_i,
   input  rf_wr_req_t            push_data_i,
   input  logic                  pop_i,
   output rf_wr_req_t            head_o,
   output logic [Depth-1:0]      valid_o,
   output logic [RfAddrMaxW-1:0] entry_addr_o [Depth],
   output logic [LvlW-1:0]       level_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]  cnt_q, cnt_d;
   logic [Depth-1:0] valid_q, valid_d;
   rf_wr_req_t       mem_q [Depth];
   rf_wr_req_t       mem_d [Depth];

   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   // Pop is applied before push so a full FIFO can accept a push into the slot it frees.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      mem_d    = mem_q;
      if (pop_i) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = ptr_next(rd_ptr_q);
      end
      if (push_i) begin
         valid_d[wr_ptr_q] = 1'b1;
         mem_d[wr_ptr_q]   = push_data_i;
         wr_ptr_d          = ptr_next(wr_ptr_q);
      end
      cnt_d = cnt_q + LvlW'(push_i) - LvlW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni && ResetAll) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      head_o  = mem_q[rd_ptr_q];
      valid_o = valid_q;
      level_o = cnt_q;
      for (int unsigned i = 0; i < Depth; i++) begin
         entry_addr_o[i] = mem_q[i].waddr;
      end
   end

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (push_i && (cnt_q == LvlW'(Depth))) |-> pop_i);
`endif

endmodule

// File: rtl/ibex_rf_wport_arb.sv
// RF write-port arbiter: WB results (req/gnt) vs non-stallable LSU returns with a park FIFO.
// Optional perf ports/counter enabled by defining IBEX_RF_WPORT_ARB_PERF_EN.
module ibex_rf_wport_arb
   import ibex_pkg::*;
#(
   parameter int unsigned NumPhysicalRegs = 64,
   parameter int unsigned FifoDepth       = 2,
   parameter bit          ResetAll        = 1'b0,
   localparam int unsigned AW             = $clog2(NumPhysicalRegs),
   localparam int unsigned LvlW           = $clog2(FifoDepth + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wb_req_i,
   input  logic [AW-1:0]              wb_waddr_i,
   input  logic [31:0]                wb_wdata_i,
   output logic                       wb_gnt_o,
   input  logic                       lsu_we_i,
   input  logic [AW-1:0]              lsu_waddr_i,
   input  logic [31:0]                lsu_wdata_i,
   output logic                       rf_we_o,
   output logic [AW-1:0]              rf_waddr_o,
   output logic [31:0]                rf_wdata_o,
   output logic [NumPhysicalRegs-1:0] pending_o,
   output logic [LvlW-1:0]            fifo_level_o,
   output logic                       idle_o
`ifdef IBEX_RF_WPORT_ARB_PERF_EN
   ,
   output logic                       perf_wb_stall_o,
   output logic [31:0]                perf_park_cnt_o
`endif
);

   rf_wr_req_t            fifo_head, lsu_new, wb_new, lsu_req, sel_req;
   logic [FifoDepth-1:0]  fifo_valid;
   logic [RfAddrMaxW-1:0] fifo_addr [FifoDepth];
   logic [LvlW-1:0]       fifo_level;
   logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic                  lsu_cand, wb_blocked, wb_wins, contested;
   logic                  rr_q, rr_d;
   logic [NumPhysicalRegs-1:0] pending;
   rf_wr_src_e            lsu_src, sel;

   ibex_rf_wr_fifo #(
      .Depth    (FifoDepth),
      .ResetAll (ResetAll)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (fifo_push),
      .push_data_i  (lsu_new),
      .pop_i        (fifo_pop),
      .head_o       (fifo_head),
      .valid_o      (fifo_valid),
      .entry_addr_o (fifo_addr),
      .level_o      (fifo_level)
   );

   always_comb begin
      pending = '0;
      for (int unsigned r = 0; r < NumPhysicalRegs; r++) begin
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            if (fifo_valid[i] && (fifo_addr[i] == RfAddrMaxW'(r))) pending[r] = 1'b1;
         end
      end
   end

   // The LSU side is the FIFO head when anything is parked, otherwise the live load bypasses.
   always_comb begin
      lsu_new    = '{waddr: RfAddrMaxW'(lsu_waddr_i), wdata: lsu_wdata_i};
      wb_new     = '{waddr: RfAddrMaxW'(wb_waddr_i), wdata: wb_wdata_i};
      fifo_empty = (fifo_level == '0);
      fifo_full  = (fifo_level == LvlW'(FifoDepth));
      lsu_src    = fifo_empty ? (lsu_we_i ? RF_WR_SRC_LSU_BYP : RF_WR_SRC_NONE)
                              : RF_WR_SRC_LSU_FIFO;
      lsu_req    = fifo_empty ? lsu_new : fifo_head;
      lsu_cand   = (lsu_src != RF_WR_SRC_NONE);
      wb_blocked = pending[wb_waddr_i];
      contested  = wb_req_i && lsu_cand;

      if (!wb_req_i)                                     wb_wins = 1'b0;
      else if (!lsu_cand)                                wb_wins = 1'b1;
      else if (fifo_full || wb_blocked)                  wb_wins = 1'b0;
      else if (fifo_empty && (wb_new.waddr == lsu_req.waddr)) wb_wins = 1'b0;
      else                                               wb_wins = !rr_q;

      sel = wb_wins ? RF_WR_SRC_WB : lsu_src;
      // After a contested grant, preference moves to the side that lost.
      rr_d      = contested ? wb_wins : rr_q;
      fifo_pop  = (sel == RF_WR_SRC_LSU_FIFO);
      fifo_push = lsu_we_i && (sel != RF_WR_SRC_LSU_BYP);

      case (sel)
         RF_WR_SRC_WB:       sel_req = wb_new;
         RF_WR_SRC_LSU_FIFO,
         RF_WR_SRC_LSU_BYP:  sel_req = lsu_req;
         default:            sel_req = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) rr_q <= 1'b0;
      else         rr_q <= rr_d;
   end

   always_comb begin
      rf_we_o      = (sel != RF_WR_SRC_NONE);
      rf_waddr_o   = AW'(sel_req.waddr);
      rf_wdata_o   = sel_req.wdata;
      wb_gnt_o     = wb_wins;
      pending_o    = pending;
      fifo_level_o = fifo_level;
      idle_o       = fifo_empty && !wb_req_i;
   end

`ifdef IBEX_RF_WPORT_ARB_PERF_EN
   logic [31:0] park_cnt_q, park_cnt_d;

   always_comb begin
      park_cnt_d = park_cnt_q;
      if (fifo_push && (park_cnt_q != '1)) park_cnt_d = park_cnt_q + 32'd1;
      perf_wb_stall_o = wb_req_i && !wb_gnt_o;
      perf_park_cnt_o = park_cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) park_cnt_q <= '0;
      else         park_cnt_q <= park_cnt_d;
   end
`endif

`ifndef SYNTHESIS
   a_wb_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (wb_req_i && !wb_gnt_o) |=> (wb_req_i && $stable(wb_waddr_i) && $stable(wb_wdata_i)));
`endif

endmodule

// File: tb/tb_ibex_rf_wport_arb.sv
// Bench for ibex_rf_wport_arb: directed scenarios plus random traffic against a queue model.
module tb_ibex_rf_wport_arb;

   localparam int unsigned NREG  = 64;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned AW    = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            wb_req, wb_gnt, lsu_we, rf_we, idle;
   logic [AW-1:0]   wb_waddr, lsu_waddr, rf_waddr;
   logic [31:0]     wb_wdata, lsu_wdata, rf_wdata;
   logic [NREG-1:0] pending;
   logic [1:0]      level;
`ifdef IBEX_RF_WPORT_ARB_PERF_EN
   logic            perf_stall;
   logic [31:0]     perf_park;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   ibex_rf_wport_arb #(
      .NumPhysicalRegs (NREG),
      .FifoDepth       (DEPTH),
      .ResetAll        (1'b0)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .wb_req_i     (wb_req),
      .wb_waddr_i   (wb_waddr),
      .wb_wdata_i   (wb_wdata),
      .wb_gnt_o     (wb_gnt),
      .lsu_we_i     (lsu_we),
      .lsu_waddr_i  (lsu_waddr),
      .lsu_wdata_i  (lsu_wdata),
      .rf_we_o      (rf_we),
      .rf_waddr_o   (rf_waddr),
      .rf_wdata_o   (rf_wdata),
      .pending_o    (pending),
      .fifo_level_o (level),
      .idle_o       (idle)
`ifdef IBEX_RF_WPORT_ARB_PERF_EN
      ,
      .perf_wb_stall_o (perf_stall),
      .perf_park_cnt_o (perf_park)
`endif
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } ent_t;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [AW-1:0] la, input logic [31:0] ld);
      wb_req = wr; wb_waddr = wa; wb_wdata = wd;
      lsu_we = lv; lsu_waddr = la; lsu_wdata = ld;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", rf_we); end
      n_cmp++; if (rf_waddr !== '0 || rf_wdata !== '0) begin n_err++; $display("FAIL reset_wport got %0d/%h want 0/0", rf_waddr, rf_wdata); end
      n_cmp++; if (wb_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt got %b want 0", wb_gnt); end
      n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL reset_pending got %h want 0", pending); end
      n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", idle); end
   endtask

   task automatic test_bypass();
      do_reset();
      drive(1'b0, '0, '0, 1'b1, 6'd5, 32'hA5);
      #1;
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 6'd5 || rf_wdata !== 32'hA5) begin
         n_err++; $display("FAIL bypass_write got we=%b a=%0d d=%h want 1/5/a5", rf_we, rf_waddr, rf_wdata); end
      n_cmp++; if (wb_gnt !== 1'b0) begin n_err++; $display("FAIL bypass_gnt got %b want 0", wb_gnt); end
      step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      #1;
      n_cmp++; if (level !== 2'd0 || rf_we !== 1'b0) begin
         n_err++; $display("FAIL bypass_after got lvl=%0d we=%b want 0/0", level, rf_we); end
   endtask

   task automatic test_park();
      do_reset();
      drive(1'b1, 6'd3, 32'h33, 1'b1, 6'd7, 32'h77);
      #1;
      n_cmp++; if (wb_gnt !== 1'b1 || rf_waddr !== 6'd3 || rf_wdata !== 32'h33) begin
         n_err++; $display("FAIL park_wb_first got gnt=%b a=%0d d=%h want 1/3/33", wb_gnt, rf_waddr, rf_wdata); end
      n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL park_pending0 got %h want 0", pending); end
      step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      #1;
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 6'd7 || rf_wdata !== 32'h77) begin
         n_err++; $display("FAIL park_drain got we=%b a=%0d d=%h want 1/7/77", rf_we, rf_waddr, rf_wdata); end
      n_cmp++; if (pending !== (64'd1 << 7) || level !== 2'd1) begin
         n_err++; $display("FAIL park_pending1 got %h lvl=%0d want %h lvl=1", pending, level, 64'd1 << 7); end
      step();
      #1;
      n_cmp++; if (pending !== '0 || level !== 2'd0 || rf_we !== 1'b0) begin
         n_err++; $display("FAIL park_cleared got pend=%h lvl=%0d we=%b want 0/0/0", pending, level, rf_we); end
   endtask

   // Fills the FIFO, then runs forced drains; leaves two entries parked for test_reset_mid.
   task automatic test_forced_drain();
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 6'd21; exp_a[1] = 6'd22; exp_a[2] = 6'd30; exp_a[3] = 6'd31;
      do_reset();
      drive(1'b1, 6'd10, 32'h10, 1'b1, 6'd20, 32'h20); step();
      drive(1'b1, 6'd11, 32'h11, 1'b1, 6'd21, 32'h21); step();
      drive(1'b1, 6'd11, 32'h11, 1'b1, 6'd22, 32'h22);
      #1;
      n_cmp++; if (wb_gnt !== 1'b1) begin n_err++; $display("FAIL fill_gnt got %b want 1", wb_gnt); end
      step();
      for (int unsigned k = 0; k < 4; k++) begin
         drive(1'b1, 6'd12, 32'h12, 1'b1, AW'(30 + k), 32'h300 + k);
         #1;
         n_cmp++; if (wb_gnt !== 1'b0 || level !== 2'd2) begin
            n_err++; $display("FAIL drain_%0d got gnt=%b lvl=%0d want 0/2", k, wb_gnt, level); end
         n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== exp_a[k]) begin
            n_err++; $display("FAIL drain_order_%0d got we=%b a=%0d want 1/%0d", k, rf_we, rf_waddr, exp_a[k]); end
         step();
      end
      #1;
      n_cmp++; if (pending !== ((64'd1 << 32) | (64'd1 << 33)) || level !== 2'd2) begin
         n_err++; $display("FAIL drain_end got pend=%h lvl=%0d want %h/2", pending, level, (64'd1 << 32) | (64'd1 << 33)); end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      n_cmp++; if (level !== 2'd0 || pending !== '0 || idle !== 1'b1 || rf_we !== 1'b0) begin
         n_err++; $display("FAIL reset_mid got lvl=%0d pend=%h idle=%b we=%b want 0/0/1/0", level, pending, idle, rf_we); end
   endtask

   task automatic test_waw_block();
      do_reset();
      drive(1'b1, 6'd3, 32'h3, 1'b1, 6'd9, 32'h90); step();
      drive(1'b1, 6'd9, 32'h99, 1'b0, '0, '0);
      #1;
      n_cmp++; if (wb_gnt !== 1'b0 || rf_waddr !== 6'd9 || rf_wdata !== 32'h90) begin
         n_err++; $display("FAIL waw_blocked got gnt=%b a=%0d d=%h want 0/9/90", wb_gnt, rf_waddr, rf_wdata); end
      n_cmp++; if (pending[9] !== 1'b1) begin n_err++; $display("FAIL waw_pending got %b want 1", pending[9]); end
      step();
      #1;
      n_cmp++; if (wb_gnt !== 1'b1 || rf_waddr !== 6'd9 || rf_wdata !== 32'h99) begin
         n_err++; $display("FAIL waw_granted got gnt=%b a=%0d d=%h want 1/9/99", wb_gnt, rf_waddr, rf_wdata); end
      step();
   endtask

   task automatic test_same_addr();
      do_reset();
      drive(1'b1, 6'd4, 32'h22, 1'b1, 6'd4, 32'h11);
      #1;
      n_cmp++; if (wb_gnt !== 1'b0 || rf_wdata !== 32'h11 || rf_waddr !== 6'd4) begin
         n_err++; $display("FAIL same_lsu_first got gnt=%b a=%0d d=%h want 0/4/11", wb_gnt, rf_waddr, rf_wdata); end
      step();
      drive(1'b1, 6'd4, 32'h22, 1'b0, '0, '0);
      #1;
      n_cmp++; if (wb_gnt !== 1'b1 || rf_wdata !== 32'h22 || level !== 2'd0) begin
         n_err++; $display("FAIL same_wb_next got gnt=%b d=%h lvl=%0d want 1/22/0", wb_gnt, rf_wdata, level); end
      step();
   endtask

   task automatic test_random();
      ent_t          q[$];
      ent_t          lc;
      logic          rr, wb_act, lv, hazard, win, side;
      logic [AW-1:0] wa, la;
      logic [31:0]   wd, ld, exp_d;
      logic [AW-1:0] exp_a;
      logic [NREG-1:0] exp_pend;
      int unsigned   lvl, parks;
      do_reset();
      rr = 1'b0; wb_act = 1'b0; wa = '0; wd = '0; parks = 0;
      for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
         if (!wb_act && ($urandom_range(0, 2) != 0)) begin
            wb_act = 1'b1; wa = AW'($urandom_range(0, 15)); wd = $urandom;
         end
         lv = 1'($urandom_range(0, 1));
         la = AW'($urandom_range(0, 15));
         ld = $urandom;
         drive(wb_act, wa, wd, lv, la, ld);
         #1;
         lvl  = q.size();
         side = (lvl != 0) || lv;
         lc   = (lvl != 0) ? q[0] : '{a: la, d: ld};
         hazard = 1'b0;
         exp_pend = '0;
         foreach (q[k]) begin
            if (q[k].a == wa) hazard = 1'b1;
            exp_pend[q[k].a] = 1'b1;
         end
         if (!wb_act)                        win = 1'b0;
         else if (!side)                     win = 1'b1;
         else if (lvl == DEPTH || hazard)    win = 1'b0;
         else if (lvl == 0 && wa == la)      win = 1'b0;
         else                                win = !rr;
         exp_a = win ? wa : (side ? lc.a : '0);
         exp_d = win ? wd : (side ? lc.d : '0);
         n_cmp++; if (wb_gnt !== win) begin n_err++; $display("FAIL rnd_gnt c%0d got %b want %b", cyc, wb_gnt, win); end
         n_cmp++; if (rf_we !== (win | side) || rf_waddr !== exp_a || rf_wdata !== exp_d) begin
            n_err++; $display("FAIL rnd_wport c%0d got %b/%0d/%h want %b/%0d/%h", cyc, rf_we, rf_waddr, rf_wdata, win | side, exp_a, exp_d); end
         n_cmp++; if (pending !== exp_pend || level !== 2'(lvl) || idle !== (lvl == 0 && !wb_act)) begin
            n_err++; $display("FAIL rnd_state c%0d got pend=%h lvl=%0d idle=%b want %h/%0d/%b", cyc, pending, level, idle, exp_pend, lvl, lvl == 0 && !wb_act); end
`ifdef IBEX_RF_WPORT_ARB_PERF_EN
         n_cmp++; if (perf_stall !== (wb_act && !win) || perf_park !== parks) begin
            n_err++; $display("FAIL rnd_perf c%0d got %b/%0d want %b/%0d", cyc, perf_stall, perf_park, wb_act && !win, parks); end
`endif
         if (wb_act && side) rr = win;
         if (!win && lvl != 0) void'(q.pop_front());
         if (lv && !(lvl == 0 && !win)) begin
            q.push_back('{a: la, d: ld});
            parks++;
         end
         if (win) wb_act = 1'b0;
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);
      test_reset();
      test_bypass();
      test_park();
      test_forced_drain();
      test_reset_mid();
      test_waw_block();
      test_same_addr();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
